// File: rtl/if_id_buffer.sv
// Two-entry skid buffer between fetch and decode. o_ready is driven only by
// registered occupancy, so a decode stall never forms a combinational path back to the PC.
module if_id_buffer #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [31:0] i_PC,
  input  logic [31:0] i_instr,
  output logic        o_ready,
  output logic        o_D_valid,
  output logic [31:0] o_D_PC,
  output logic [31:0] o_D_PC8,
  output logic [31:0] o_D_instr,
  input  logic        i_D_ready,
  output logic [1:0]  o_count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic        wp, rp;
  logic [1:0]  count;
  logic        push, pop;

  function automatic logic [31:0] link_addr(input logic [31:0] pc);
    return pc + 32'd8;
  endfunction

  assign o_ready   = (count != FULL);
  assign o_D_valid = (count != 2'd0);
  assign push      = i_valid & o_ready & ~i_flush;
  assign pop       = o_D_valid & i_D_ready & ~i_flush;

  // Control state: reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      count <= 2'd0;
      wp    <= 1'b0;
      rp    <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Entry storage carries no reset; contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wp]    <= i_PC;
      instr_mem[wp] <= i_instr;
    end
  end

  assign o_D_PC    = o_D_valid ? pc_mem[rp]    : 32'h0;
  assign o_D_instr = o_D_valid ? instr_mem[rp] : NOP;
  assign o_D_PC8   = link_addr(o_D_PC);
  assign o_count   = count;

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed vector table followed by randomized traffic
// checked against a queue-based model of the buffer.
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, i_flush, i_valid, i_D_ready;
  logic [31:0] i_PC, i_instr;
  logic        o_ready, o_D_valid;
  logic [31:0] o_D_PC, o_D_PC8, o_D_instr;
  logic [1:0]  o_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_buffer #(.DEPTH(2), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid),
    .i_PC(i_PC), .i_instr(i_instr), .o_ready(o_ready), .o_D_valid(o_D_valid),
    .o_D_PC(o_D_PC), .o_D_PC8(o_D_PC8), .o_D_instr(o_D_instr),
    .i_D_ready(i_D_ready), .o_count(o_count)
  );

  typedef struct {
    logic        rst, fl, vld;
    logic [31:0] pc;
    logic        drdy;
    logic        e_vld;
    logic [31:0] e_pc, e_pc8;
    logic        e_rdy;
    logic [1:0]  e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  function automatic vec_t mk(logic rst, logic fl, logic vld, logic [31:0] pc, logic drdy,
                              logic e_vld, logic [31:0] e_pc, logic [31:0] e_pc8,
                              logic e_rdy, logic [1:0] e_cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.vld = vld; v.pc = pc; v.drdy = drdy;
    v.e_vld = e_vld; v.e_pc = e_pc; v.e_pc8 = e_pc8; v.e_rdy = e_rdy; v.e_cnt = e_cnt;
    return v;
  endfunction

  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return ~pc ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(string tag, logic e_vld, logic [31:0] e_pc, logic [31:0] e_pc8,
                               logic [31:0] e_instr, logic e_rdy, logic [1:0] e_cnt);
    chk({tag, ".valid"}, 32'(o_D_valid), 32'(e_vld));
    chk({tag, ".pc"},    o_D_PC,         e_pc);
    chk({tag, ".pc8"},   o_D_PC8,        e_pc8);
    chk({tag, ".instr"}, o_D_instr,      e_instr);
    chk({tag, ".ready"}, 32'(o_ready),   32'(e_rdy));
    chk({tag, ".count"}, 32'(o_count),   32'(e_cnt));
  endtask

  vec_t   vecs[25];
  entry_t q[$];

  initial begin
    reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_D_ready = 1'b0;
    i_PC = '0; i_instr = '0;

    //         rst fl vld pc            drdy  e_vld e_pc          e_pc8         rdy cnt
    vecs[0]  = mk(1, 0, 0, 32'h0,        0,    0, 32'h0,        32'h8,        1, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,        0,    0, 32'h0,        32'h8,        1, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,        1,    0, 32'h0,        32'h8,        1, 0);
    vecs[3]  = mk(0, 0, 1, 32'h3000,     1,    1, 32'h3000,     32'h3008,     1, 1);
    vecs[4]  = mk(0, 0, 1, 32'h3004,     1,    1, 32'h3004,     32'h300C,     1, 1);
    vecs[5]  = mk(0, 0, 1, 32'h3008,     1,    1, 32'h3008,     32'h3010,     1, 1);
    vecs[6]  = mk(0, 0, 0, 32'h0,        1,    0, 32'h0,        32'h8,        1, 0);
    vecs[7]  = mk(0, 0, 1, 32'h3000,     0,    1, 32'h3000,     32'h3008,     1, 1);
    vecs[8]  = mk(0, 0, 1, 32'h3004,     0,    1, 32'h3000,     32'h3008,     0, 2);
    vecs[9]  = mk(0, 0, 1, 32'h3008,     0,    1, 32'h3000,     32'h3008,     0, 2);
    vecs[10] = mk(0, 0, 1, 32'h3008,     1,    1, 32'h3004,     32'h300C,     1, 1);
    vecs[11] = mk(0, 0, 1, 32'h3008,     1,    1, 32'h3008,     32'h3010,     1, 1);
    vecs[12] = mk(0, 0, 0, 32'h0,        1,    0, 32'h0,        32'h8,        1, 0);
    vecs[13] = mk(0, 0, 1, 32'h4100,     0,    1, 32'h4100,     32'h4108,     1, 1);
    vecs[14] = mk(0, 0, 1, 32'h4104,     0,    1, 32'h4100,     32'h4108,     0, 2);
    vecs[15] = mk(0, 1, 1, 32'h4180,     0,    0, 32'h0,        32'h8,        1, 0);
    vecs[16] = mk(0, 0, 0, 32'h0,        0,    0, 32'h0,        32'h8,        1, 0);
    vecs[17] = mk(0, 0, 1, 32'h3000,     0,    1, 32'h3000,     32'h3008,     1, 1);
    vecs[18] = mk(0, 0, 1, 32'h3004,     1,    1, 32'h3004,     32'h300C,     1, 1);
    vecs[19] = mk(0, 0, 0, 32'h0,        1,    0, 32'h0,        32'h8,        1, 0);
    vecs[20] = mk(0, 0, 1, 32'hFFFFFFFC, 0,    1, 32'hFFFFFFFC, 32'h4,        1, 1);
    vecs[21] = mk(1, 0, 0, 32'h0,        0,    0, 32'h0,        32'h8,        1, 0);
    vecs[22] = mk(0, 0, 1, 32'h5000,     0,    1, 32'h5000,     32'h5008,     1, 1);
    vecs[23] = mk(0, 0, 1, 32'h5004,     0,    1, 32'h5000,     32'h5008,     0, 2);
    vecs[24] = mk(1, 0, 1, 32'h5008,     0,    0, 32'h0,        32'h8,        1, 0);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; i_flush = vecs[i].fl; i_valid = vecs[i].vld;
      i_PC = vecs[i].pc; i_instr = instr_of(vecs[i].pc); i_D_ready = vecs[i].drdy;
      @(posedge clk); #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_pc, vecs[i].e_pc8,
                    vecs[i].e_vld ? instr_of(vecs[i].e_pc) : NOP, vecs[i].e_rdy, vecs[i].e_cnt);
    end

    // Randomized traffic; buffer is empty after the last vector.
    q.delete();
    for (int n = 0; n < 2000; n++) begin
      logic        r_rst, r_fl, r_vld, r_rdy, m_ready;
      logic [31:0] r_pc, r_ins;
      entry_t      e;
      r_rst = ($urandom_range(0, 99) < 2);
      r_fl  = ($urandom_range(0, 99) < 5);
      r_vld = ($urandom_range(0, 99) < 70);
      r_rdy = ($urandom_range(0, 99) < 55);
      r_pc  = $urandom;
      r_ins = $urandom;
      @(negedge clk);
      reset = r_rst; i_flush = r_fl; i_valid = r_vld; i_D_ready = r_rdy;
      i_PC = r_pc; i_instr = r_ins;
      m_ready = (q.size() < 2);
      if (r_rst || r_fl) begin
        q.delete();
      end else begin
        if (q.size() > 0 && r_rdy) void'(q.pop_front());
        if (r_vld && m_ready) begin
          e.pc = r_pc; e.instr = r_ins;
          q.push_back(e);
        end
      end
      @(posedge clk); #1;
      if (q.size() > 0)
        check_outputs("rand", 1'b1, q[0].pc, q[0].pc + 32'd8, q[0].instr,
                      q.size() < 2, 2'(q.size()));
      else
        check_outputs("rand", 1'b0, 32'h0, 32'h8, NOP, 1'b1, 2'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
